div_iter_unit: RTL and testbench
================================

Name: div_iter_unit

Overview:
- Multi-cycle iterative 32-bit integer divider in the execute stage of the 5-stage MIPS pipeline.
- Produces `stall_div`, which the hazard unit consumes as `stall_divE`. While it is high, the hazard unit stalls F/D/E.
- When stall drops, `result_hi`/`result_lo` are valid and are captured into HI/LO as the instruction leaves E.
- Covers DIV and DIVU.

Parameters:
- `WIDTH`, 32, operand/result width in bits.
- `CNT_W`, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk` input 1: clock, all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: DIV/DIVU instruction present in E; held high for as long as that instruction sits in E.
- `signed_div` input 1: 1 = DIV (two's complement), 0 = DIVU. Sampled with `start`.
- `annul` input 1: cancel request (E flush or exception); synchronous.
- `a` input WIDTH: dividend (rs value after forwarding). Sampled with `start`.
- `b` input WIDTH: divisor (rt value after forwarding). Sampled with `start`.
- `stall_div` output 1: pipeline stall request to the hazard unit.
- `ready` output 1: results valid this cycle.
- `result_hi` output WIDTH: remainder.
- `result_lo` output WIDTH: quotient.

Behaviour:
- States: IDLE, BUSY, DONE. Reset state is IDLE.
  - Reset outputs: `stall_div`=0, `ready`=0, `result_hi`=0, `result_lo`=0, counter=0.
  - `rst` mid-operation returns to IDLE immediately and discards the operation.
- IDLE:
  - With `start`=1 and `annul`=0:
    - Latch |a| and |b| (magnitudes if `signed_div`, raw values otherwise).
    - Latch quotient sign = a[MSB]^b[MSB] and remainder sign = a[MSB] (both forced 0 when `signed_div`=0).
    - Latch a div-by-zero flag (b==0) and the original a.
    - Clear the partial remainder; counter=0; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - One restoring radix-2 step per cycle: shift {rem,quo} left by 1, trial subtract divisor, set the quotient LSB on no borrow.
  - Counter increments each step. After step WIDTH (counter==WIDTH-1 at the edge), go to DONE.
- DONE:
  - Lasts exactly one cycle, then unconditionally returns to IDLE.
  - `start` is still high in the DONE cycle (same instruction); it must not restart the divider.
  - A back-to-back divide arriving in E the next cycle starts normally from IDLE.
- `stall_div` (combinational) = (IDLE & `start` & ~`annul`) | (BUSY & ~`annul`). It is 0 in DONE.
  - Total stall per divide: WIDTH+1 = 33 cycles. The instruction leaves E on the DONE cycle.
- `ready` = (state==DONE). `result_hi`/`result_lo` are registered and hold their value until the next DONE.
- Sign correction (applied when entering DONE):
  - quotient = q_sign ? −q : q.
  - remainder = r_sign ? −r : r.
  - Results are truncated to WIDTH.
- Overflow: −2^31 / −1 gives lo=0x80000000, hi=0 (natural wrap). No trap.
- Divide by zero: hi = original a, lo = all-ones, regardless of sign; full latency still applies.
- `annul` in BUSY or IDLE: go to IDLE at the next edge. `stall_div` drops in the same cycle. Results are unchanged and `ready` is not asserted.
- `annul` in DONE: no effect (results already committed).
- Inputs `a`, `b`, `signed_div` are ignored outside the IDLE start cycle.

Optional Feature:
- Macro: `DIV_EARLY_EXIT_EN`.
- Defined, start cycle in IDLE:
  - If b==0, or |a| < |b| (unsigned compare of the latched magnitudes), go directly to DONE.
  - `stall_div` is high only in that one start cycle (1-cycle stall).
  - Results: quotient 0 and remainder a, or the divide-by-zero values above.
- Undefined: every divide takes the full WIDTH+1 stall cycles.

Test Plan:
- Reset: assert `rst` asynchronously mid-BUSY → `stall_div`=0, `ready`=0, `result_hi`/`result_lo`=0 immediately. The next `start` is accepted normally.
- DIVU a=100, b=7, `start` held → `stall_div`=1 for exactly 33 cycles; DONE cycle: `ready`=1, lo=14, hi=2. IDLE the following cycle.
- DIV a=−100 (0xFFFFFF9C), b=7 → lo=0xFFFFFFF2 (−14), hi=0xFFFFFFFE (−2).
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5.
- Back-to-back: DIVU 9/2 then DIVU 20/3, with `start` staying high across DONE:
  - First result lo=4, hi=1, and no restart in its DONE cycle.
  - Second starts from IDLE the next cycle; lo=6, hi=2 after another 33 stall cycles.
- `annul` at BUSY cycle 10 → `stall_div` drops that cycle, IDLE next edge, `ready` never asserted, previous results retained.
- With `DIV_EARLY_EXIT_EN`: DIVU 3/10 → 1 stall cycle, lo=0, hi=3.

Source files
------------

// File: rtl/div_iter_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU in the execute stage; holds the pipeline via stall_div.
// Define DIV_EARLY_EXIT_EN to finish divide-by-zero and |a| < |b| in the start cycle.
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall_div,
    output logic             ready,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] a_orig;
    logic             q_sign;
    logic             r_sign;
    logic             dbz;

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             accept, early, last;

    assign a_neg  = signed_div & a[WIDTH-1];
    assign b_neg  = signed_div & b[WIDTH-1];
    assign mag_a  = cond_neg(a_neg, a);
    assign mag_b  = cond_neg(b_neg, b);
    assign b_zero = (b == '0);
    assign accept = (state == IDLE) & start & ~annul;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_EARLY_EXIT_EN
    assign early = b_zero | (mag_a < mag_b);
`else
    assign early = 1'b0;
`endif

    // One restoring step: shift {rem,quo} left, trial-subtract, keep on no borrow
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign diff      = rem_sh - {1'b0, dvs};
    assign no_borrow = ~diff[WIDTH];
    assign rem_step  = no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_step  = {quo[WIDTH-2:0], no_borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_div = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                stall_div = start & ~annul;
                if (accept) state_nxt = early ? DONE : BUSY;
            end
            BUSY: begin
                stall_div = ~annul;
                if (annul)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter and committed results; results only change when entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            if (accept) begin
                cnt <= '0;
                if (early) begin
                    result_lo <= b_zero ? '1 : '0;
                    result_hi <= a;
                end
            end else if (state == BUSY && !annul) begin
                cnt <= cnt + 1'b1;
                if (last) begin
                    result_lo <= dbz ? '1 : cond_neg(q_sign, quo_step);
                    result_hi <= dbz ? a_orig : cond_neg(r_sign, rem_step);
                end
            end
        end
    end

    // Operand latches and iteration datapath
    always_ff @(posedge clk) begin
        if (accept) begin
            dvs    <= mag_b;
            quo    <= mag_a;
            rem    <= '0;
            q_sign <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_sign <= a_neg;
            dbz    <= b_zero;
            a_orig <= a;
        end else if (state == BUSY) begin
            rem <= rem_step;
            quo <= quo_step;
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: latency, results, back-to-back, annul and async reset.
module tb_div_iter_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall_div;
    logic        ready;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam int SHORT = 1;
`else
    localparam int SHORT = 33;
`endif

    div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .a          (a),
        .b          (b),
        .stall_div  (stall_div),
        .ready      (ready),
        .result_hi  (result_hi),
        .result_lo  (result_lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge; leaves just after the edge that ends DONE, start untouched
    task automatic run_div(input string tag, input logic sd, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int exp_stalls);
        int stalls;
        bit seen;
        start      = 1'b1;
        signed_div = sd;
        a          = av;
        b          = bv;
        stalls     = 0;
        seen       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                break;
            end
            if (stall_div) stalls++;
        end
        check_val({tag, "_ready"}, 32'(seen), 32'd1);
        check_val({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        check_val({tag, "_lo"}, result_lo, exp_lo);
        check_val({tag, "_hi"}, result_hi, exp_hi);
        check_val({tag, "_done_stall"}, 32'(stall_div), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        start = 1'b0;
        @(negedge clk);
        check_val({tag, "_idle_ready"}, 32'(ready), 32'd0);
        check_val({tag, "_idle_stall"}, 32'(stall_div), 32'd0);
        check_val({tag, "_hold_lo"}, result_lo, exp_lo);
        check_val({tag, "_hold_hi"}, result_hi, exp_hi);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        annul      = 1'b0;
        a          = '0;
        b          = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_stall", 32'(stall_div), 32'd0);
        check_val("rst_ready", 32'(ready), 32'd0);
        check_val("rst_lo", result_lo, 32'd0);
        check_val("rst_hi", result_hi, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        idle_check("divu_100_7", 32'd14, 32'd2);

        run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
        idle_check("div_m100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE);

        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        idle_check("div_ovf", 32'h8000_0000, 32'd0);

        run_div("divu_dbz", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, SHORT);
        idle_check("divu_dbz", 32'hFFFF_FFFF, 32'd5);

        run_div("div_dbz_neg", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, SHORT);
        idle_check("div_dbz_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF9);

        run_div("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, SHORT);
        idle_check("divu_3_10", 32'd0, 32'd3);

        // Back-to-back: start stays high through DONE into the next instruction
        run_div("b2b_9_2", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 33);
        run_div("b2b_20_3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 33);
        idle_check("b2b_20_3", 32'd6, 32'd2);

        // Annul on the tenth BUSY cycle
        start      = 1'b1;
        signed_div = 1'b0;
        a          = 32'd100;
        b          = 32'd7;
        @(posedge clk);
        #1;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        @(negedge clk);
        check_val("annul_stall", 32'(stall_div), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check_val("annul_no_ready", 32'(seen), 32'd0);
        check_val("annul_lo", result_lo, 32'd6);
        check_val("annul_hi", result_hi, 32'd2);
        check_val("annul_idle_stall", 32'(stall_div), 32'd0);

        // Asynchronous reset mid-BUSY
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        repeat (5) @(posedge clk);
        #3;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check_val("async_rst_stall", 32'(stall_div), 32'd0);
        check_val("async_rst_ready", 32'(ready), 32'd0);
        check_val("async_rst_lo", result_lo, 32'd0);
        check_val("async_rst_hi", result_hi, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_div("after_rst", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 33);
        idle_check("after_rst", 32'd6, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
